// File: rtl/l2_backing_memory.sv
`default_nettype none
//==============================================================================
// Module   : l2_backing_memory
// Brief    : Unified L2 backing store: three 1-deep request slots, fixed-priority
//            arbitration (WR > RD > INS), single-ported RAM with fixed latency.
// Revision : 1.0
//==============================================================================
module l2_backing_memory #(
    parameter int    L2_BUS_WIDTH   = 32,
    parameter int    ADDRESS_WIDTH  = 32,
    parameter int    MEM_ADDR_WIDTH = 12,
    parameter int    ACCESS_LATENCY = 2,
    parameter string INIT_FILE      = ""
) (
    input  logic                     CLK,
    input  logic                     RST,
    output logic                     ADDRESS_TO_L2_READY_INS,
    input  logic                     ADDRESS_TO_L2_VALID_INS,
    input  logic [ADDRESS_WIDTH-3:0] ADDRESS_TO_L2_INS,
    output logic                     DATA_FROM_L2_VALID_INS,
    input  logic                     DATA_FROM_L2_READY_INS,
    output logic [L2_BUS_WIDTH-1:0]  DATA_FROM_L2_INS,
    output logic                     WRITE_TO_L2_READY_DATA,
    input  logic                     WRITE_TO_L2_VALID_DATA,
    input  logic [ADDRESS_WIDTH-3:0] WRITE_ADDR_TO_L2_DATA,
    input  logic [L2_BUS_WIDTH-1:0]  DATA_TO_L2_DATA,
    input  logic                     WRITE_CONTROL_TO_L2_DATA,
    output logic                     WRITE_COMPLETE_DATA,
    output logic                     READ_ADDR_TO_L2_READY_DATA,
    input  logic                     READ_ADDR_TO_L2_VALID_DATA,
    input  logic [ADDRESS_WIDTH-3:0] READ_ADDR_TO_L2_DATA,
    input  logic                     DATA_FROM_L2_READY_DATA,
    output logic                     DATA_FROM_L2_VALID_DATA,
    output logic [L2_BUS_WIDTH-1:0]  DATA_FROM_L2_DATA
);

    localparam int                  c_CNT_W   = $clog2(ACCESS_LATENCY + 1);
    localparam logic [c_CNT_W-1:0]  c_LAT     = c_CNT_W'(ACCESS_LATENCY);
    localparam logic [c_CNT_W-1:0]  c_ONE     = c_CNT_W'(1);
    localparam logic [1:0]          c_SEL_WR  = 2'd0;
    localparam logic [1:0]          c_SEL_RD  = 2'd1;
    localparam logic [1:0]          c_SEL_INS = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    state_t                    r_state, w_state_nxt;
    logic [1:0]                r_sel, w_sel_nxt;
    logic [c_CNT_W-1:0]        r_cnt, w_cnt_nxt;
    logic                      w_commit, w_resp_done;

    logic [L2_BUS_WIDTH-1:0]   r_mem [0:(1<<MEM_ADDR_WIDTH)-1];

    logic                      r_wr_pend, r_rd_pend, r_ins_pend;
    logic                      r_wr_ready, r_rd_ready, r_ins_ready;
    logic [MEM_ADDR_WIDTH-1:0] r_wr_addr, r_rd_addr, r_ins_addr;
    logic [L2_BUS_WIDTH-1:0]   r_wr_data;
    logic                      r_wr_ctrl;
    logic                      r_wr_done;
    logic                      r_rd_valid, r_ins_valid;
    logic [L2_BUS_WIDTH-1:0]   r_rd_data, r_ins_data;

    logic                      w_acc_wr, w_acc_rd, w_acc_ins;
    logic                      w_clr_wr, w_clr_rd, w_clr_ins;
    logic                      w_wr_pend_nxt, w_rd_pend_nxt, w_ins_pend_nxt;
    logic [MEM_ADDR_WIDTH-1:0] w_addr;
    logic [L2_BUS_WIDTH-1:0]   w_rdata;
    logic                      w_unused_addr;

    // Only the low MEM_ADDR_WIDTH address bits select a word; the rest alias.
    assign w_unused_addr = ^{ADDRESS_TO_L2_INS[ADDRESS_WIDTH-3:MEM_ADDR_WIDTH],
                             WRITE_ADDR_TO_L2_DATA[ADDRESS_WIDTH-3:MEM_ADDR_WIDTH],
                             READ_ADDR_TO_L2_DATA[ADDRESS_WIDTH-3:MEM_ADDR_WIDTH]};

    assign w_acc_wr  = WRITE_TO_L2_VALID_DATA     & r_wr_ready;
    assign w_acc_rd  = READ_ADDR_TO_L2_VALID_DATA & r_rd_ready;
    assign w_acc_ins = ADDRESS_TO_L2_VALID_INS    & r_ins_ready;

    assign w_clr_wr  = w_commit    & (r_sel == c_SEL_WR);
    assign w_clr_rd  = w_resp_done & (r_sel == c_SEL_RD);
    assign w_clr_ins = w_resp_done & (r_sel == c_SEL_INS);

    assign w_wr_pend_nxt  = (r_wr_pend  & ~w_clr_wr)  | w_acc_wr;
    assign w_rd_pend_nxt  = (r_rd_pend  & ~w_clr_rd)  | w_acc_rd;
    assign w_ins_pend_nxt = (r_ins_pend & ~w_clr_ins) | w_acc_ins;

    always_comb begin
        w_addr = r_ins_addr;
        case (r_sel)
            c_SEL_WR: w_addr = r_wr_addr;
            c_SEL_RD: w_addr = r_rd_addr;
            default:  w_addr = r_ins_addr;
        endcase
    end

    assign w_rdata = r_mem[w_addr];

    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt   = r_sel;
        w_cnt_nxt   = r_cnt;
        w_commit    = 1'b0;
        w_resp_done = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_wr_pend | r_rd_pend | r_ins_pend) begin
                    w_state_nxt = ST_ACCESS;
                    w_cnt_nxt   = c_LAT;
                    w_sel_nxt   = r_wr_pend ? c_SEL_WR : (r_rd_pend ? c_SEL_RD : c_SEL_INS);
                end
            end
            ST_ACCESS: begin
                w_cnt_nxt = r_cnt - c_ONE;
                if (r_cnt == c_ONE) begin
                    w_commit    = 1'b1;
                    w_state_nxt = (r_sel == c_SEL_WR) ? ST_IDLE : ST_RESP;
                end
            end
            ST_RESP: begin
                if (((r_sel == c_SEL_RD)  && DATA_FROM_L2_READY_DATA) ||
                    ((r_sel == c_SEL_INS) && DATA_FROM_L2_READY_INS)) begin
                    w_resp_done = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= ST_IDLE;
            r_sel   <= c_SEL_WR;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_sel   <= w_sel_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // RAM contents survive reset; a reset on the commit edge cancels the write.
    always_ff @(posedge CLK) begin
        if (!RST && w_clr_wr && r_wr_ctrl) begin
            r_mem[r_wr_addr] <= r_wr_data;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_wr_pend   <= 1'b0;
            r_rd_pend   <= 1'b0;
            r_ins_pend  <= 1'b0;
            r_wr_ready  <= 1'b0;
            r_rd_ready  <= 1'b0;
            r_ins_ready <= 1'b0;
            r_wr_addr   <= '0;
            r_rd_addr   <= '0;
            r_ins_addr  <= '0;
            r_wr_data   <= '0;
            r_wr_ctrl   <= 1'b0;
            r_wr_done   <= 1'b0;
            r_rd_valid  <= 1'b0;
            r_rd_data   <= '0;
            r_ins_valid <= 1'b0;
            r_ins_data  <= '0;
        end else begin
            if (w_acc_wr) begin
                r_wr_addr <= WRITE_ADDR_TO_L2_DATA[MEM_ADDR_WIDTH-1:0];
                r_wr_data <= DATA_TO_L2_DATA;
                r_wr_ctrl <= WRITE_CONTROL_TO_L2_DATA;
            end
            if (w_acc_rd)  r_rd_addr  <= READ_ADDR_TO_L2_DATA[MEM_ADDR_WIDTH-1:0];
            if (w_acc_ins) r_ins_addr <= ADDRESS_TO_L2_INS[MEM_ADDR_WIDTH-1:0];

            r_wr_pend   <= w_wr_pend_nxt;
            r_rd_pend   <= w_rd_pend_nxt;
            r_ins_pend  <= w_ins_pend_nxt;
            r_wr_ready  <= ~w_wr_pend_nxt;
            r_rd_ready  <= ~w_rd_pend_nxt;
            r_ins_ready <= ~w_ins_pend_nxt;
            r_wr_done   <= w_clr_wr;

            if (w_commit && (r_sel == c_SEL_RD)) begin
                r_rd_valid <= 1'b1;
                r_rd_data  <= w_rdata;
            end else if (w_clr_rd) begin
                r_rd_valid <= 1'b0;
                r_rd_data  <= '0;
            end
            if (w_commit && (r_sel == c_SEL_INS)) begin
                r_ins_valid <= 1'b1;
                r_ins_data  <= w_rdata;
            end else if (w_clr_ins) begin
                r_ins_valid <= 1'b0;
                r_ins_data  <= '0;
            end
        end
    end

    assign ADDRESS_TO_L2_READY_INS    = r_ins_ready;
    assign WRITE_TO_L2_READY_DATA     = r_wr_ready;
    assign READ_ADDR_TO_L2_READY_DATA = r_rd_ready;
    assign WRITE_COMPLETE_DATA        = r_wr_done;
    assign DATA_FROM_L2_VALID_DATA    = r_rd_valid;
    assign DATA_FROM_L2_DATA          = r_rd_data;
    assign DATA_FROM_L2_VALID_INS     = r_ins_valid;
    assign DATA_FROM_L2_INS           = r_ins_data;

endmodule
`default_nettype wire

// File: tb/tb_l2_backing_memory.sv
`default_nettype none
//==============================================================================
// Module   : tb_l2_backing_memory
// Brief    : Self-checking bench for l2_backing_memory: event-time reference
//            model compared every cycle, plus directed literal scenarios.
// Revision : 1.0
//==============================================================================
module tb_l2_backing_memory;

    localparam int AW  = 32;
    localparam int W   = 32;
    localparam int MAW = 12;
    localparam int L   = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ins_v = 0, ins_r = 1, wr_v = 0, wr_c = 0, rd_v = 0, rd_r = 1;
    logic [AW-3:0] ins_a = '0, wr_a = '0, rd_a = '0;
    logic [W-1:0]  wr_d = '0;

    logic          rdy_ins, vld_ins, rdy_wr, done, rdy_rd, vld_rd;
    logic [W-1:0]  dat_ins, dat_rd;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    l2_backing_memory #(
        .L2_BUS_WIDTH(W), .ADDRESS_WIDTH(AW), .MEM_ADDR_WIDTH(MAW),
        .ACCESS_LATENCY(L), .INIT_FILE("")
    ) dut (
        .CLK(clk), .RST(rst),
        .ADDRESS_TO_L2_READY_INS(rdy_ins), .ADDRESS_TO_L2_VALID_INS(ins_v),
        .ADDRESS_TO_L2_INS(ins_a), .DATA_FROM_L2_VALID_INS(vld_ins),
        .DATA_FROM_L2_READY_INS(ins_r), .DATA_FROM_L2_INS(dat_ins),
        .WRITE_TO_L2_READY_DATA(rdy_wr), .WRITE_TO_L2_VALID_DATA(wr_v),
        .WRITE_ADDR_TO_L2_DATA(wr_a), .DATA_TO_L2_DATA(wr_d),
        .WRITE_CONTROL_TO_L2_DATA(wr_c), .WRITE_COMPLETE_DATA(done),
        .READ_ADDR_TO_L2_READY_DATA(rdy_rd), .READ_ADDR_TO_L2_VALID_DATA(rd_v),
        .READ_ADDR_TO_L2_DATA(rd_a), .DATA_FROM_L2_READY_DATA(rd_r),
        .DATA_FROM_L2_VALID_DATA(vld_rd), .DATA_FROM_L2_DATA(dat_rd)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: slots are flags, the server is "busy until edge N".
    logic [31:0] m_mem [int];
    bit          m_pw, m_pr, m_pi, m_rw, m_rr, m_ri;
    int          m_wa, m_ra, m_ia;
    logic [31:0] m_wd;
    bit          m_wc;
    int          m_srv = -1;
    int          m_commit = 0;
    bit          m_resp = 0;
    bit          m_done = 0, m_vr = 0, m_vi = 0, m_kr = 1, m_ki = 1;
    logic [31:0] m_dr = 0, m_di = 0;
    int          edge_n = 0;

    task model_step();
        bit aw, ar, ai, cw, cr, ci;
        aw = wr_v && m_rw; ar = rd_v && m_rr; ai = ins_v && m_ri;
        cw = 0; cr = 0; ci = 0;
        m_done = 0;
        if (rst) begin
            {m_pw, m_pr, m_pi, m_rw, m_rr, m_ri} = '0;
            m_srv = -1; m_resp = 0; m_vr = 0; m_vi = 0; m_dr = 0; m_di = 0;
            m_kr = 1; m_ki = 1;
        end else begin
            if (m_srv < 0) begin
                m_srv = m_pw ? 0 : (m_pr ? 1 : (m_pi ? 2 : -1));
                m_commit = edge_n + L;
            end else if (!m_resp) begin
                if (edge_n == m_commit) begin
                    if (m_srv == 0) begin
                        if (m_wc) m_mem[m_wa] = m_wd;
                        m_done = 1; cw = 1; m_srv = -1;
                    end else if (m_srv == 1) begin
                        m_vr = 1; m_kr = m_mem.exists(m_ra);
                        m_dr = m_kr ? m_mem[m_ra] : 'x; m_resp = 1;
                    end else begin
                        m_vi = 1; m_ki = m_mem.exists(m_ia);
                        m_di = m_ki ? m_mem[m_ia] : 'x; m_resp = 1;
                    end
                end
            end else if (m_srv == 1 && rd_r) begin
                m_vr = 0; m_dr = 0; m_kr = 1; cr = 1; m_srv = -1; m_resp = 0;
            end else if (m_srv == 2 && ins_r) begin
                m_vi = 0; m_di = 0; m_ki = 1; ci = 1; m_srv = -1; m_resp = 0;
            end
            if (aw) begin m_wa = int'(wr_a % (1 << MAW)); m_wd = wr_d; m_wc = wr_c; end
            if (ar) m_ra = int'(rd_a % (1 << MAW));
            if (ai) m_ia = int'(ins_a % (1 << MAW));
            m_pw = (m_pw && !cw) || aw;
            m_pr = (m_pr && !cr) || ar;
            m_pi = (m_pi && !ci) || ai;
            m_rw = !m_pw; m_rr = !m_pr; m_ri = !m_pi;
        end
        edge_n++;
    endtask

    always @(posedge clk) begin
        model_step();
        #1;
        chk("ready_wr", rdy_wr, m_rw);
        chk("ready_rd", rdy_rd, m_rr);
        chk("ready_ins", rdy_ins, m_ri);
        chk("write_complete", done, m_done);
        chk("valid_rd", vld_rd, m_vr);
        chk("valid_ins", vld_ins, m_vi);
        if (m_kr) chk("data_rd", dat_rd, m_dr);
        if (m_ki) chk("data_ins", dat_ins, m_di);
    end

    task automatic issue(input bit dw, input int wa, input logic [31:0] wd, input bit wc,
                         input bit dr, input int ra, input bit di, input int ia);
        int n = 0;
        @(negedge clk);
        while (!((!dw || rdy_wr) && (!dr || rdy_rd) && (!di || rdy_ins)) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            total++; bad++;
            $display("FAIL issue_timeout: ready never rose");
        end
        wr_v = dw; wr_a = (AW-2)'(wa); wr_d = wd; wr_c = wc;
        rd_v = dr; rd_a = (AW-2)'(ra);
        ins_v = di; ins_a = (AW-2)'(ia);
        @(posedge clk);
        @(negedge clk);
        wr_v = 0; rd_v = 0; ins_v = 0;
    endtask

    task automatic watch(input int n, output int done_at, output int rd_at, output int ins_at,
                         output logic [31:0] rdd, output logic [31:0] insd);
        done_at = -1; rd_at = -1; ins_at = -1; rdd = 0; insd = 0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (done && done_at < 0) done_at = k;
            if (vld_rd && rd_at < 0) begin rd_at = k; rdd = dat_rd; end
            if (vld_ins && ins_at < 0) begin ins_at = k; insd = dat_ins; end
        end
    endtask

    initial begin
        int da, ra, ia;
        logic [31:0] rdd, insd;
        logic [31:0] pre [16];

        // Reset release
        repeat (3) @(negedge clk);
        chk("reset_ready", {29'd0, rdy_wr, rdy_rd, rdy_ins}, 32'd0);
        chk("reset_outputs", {28'd0, vld_rd, vld_ins, done, |{dat_rd, dat_ins}}, 32'd0);
        rst = 0;
        @(posedge clk); #1;
        chk("ready_after_reset", {29'd0, rdy_wr, rdy_rd, rdy_ins}, 32'd7);
        chk("idle_after_reset", {30'd0, vld_rd, vld_ins}, 32'd0);

        // Preload the low 16 words through the write port
        for (int i = 0; i < 16; i++) pre[i] = 32'h1000 + i;
        pre[1] = 32'hA; pre[2] = 32'hB; pre[3] = 32'h33; pre[5] = 32'hDEADBEEF; pre[7] = 32'h77;
        for (int i = 0; i < 16; i++) begin
            issue(1, i, pre[i], 1, 0, 0, 0, 0);
            watch(6, da, ra, ia, rdd, insd);
            chk("preload_done", da >= 0, 1);
        end

        // Instruction read with backpressure: VALID three edges after acceptance
        ins_r = 0;
        @(negedge clk);
        ins_v = 1; ins_a = 5;
        @(posedge clk);
        @(negedge clk);
        ins_v = 0;
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk); #1;
            chk("ins_latency_valid", vld_ins, k == 3);
        end
        chk("ins_data", dat_ins, 32'hDEADBEEF);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("ins_hold_valid", vld_ins, 1);
            chk("ins_hold_data", dat_ins, 32'hDEADBEEF);
            chk("ins_hold_ready", rdy_ins, 0);
        end
        ins_r = 1;
        @(posedge clk); #1;
        chk("ins_after_hs_valid", vld_ins, 0);
        chk("ins_after_hs_ready", rdy_ins, 1);
        chk("ins_after_hs_data", dat_ins, 0);

        // Write-before-read ordering on the same edge
        issue(1, 32'h10, 32'h12345678, 1, 1, 32'h10, 0, 0);
        watch(20, da, ra, ia, rdd, insd);
        chk("wbr_write_first", (da >= 0) && (ra > da), 1);
        chk("wbr_read_data", rdd, 32'h12345678);

        // Arbitration: data read beats instruction read
        issue(0, 0, 0, 0, 1, 1, 1, 2);
        watch(30, da, ra, ia, rdd, insd);
        chk("arb_order", (ra >= 0) && (ia > ra), 1);
        chk("arb_rd_data", rdd, 32'hA);
        chk("arb_ins_data", insd, 32'hB);

        // Write with control = 0 completes but leaves memory untouched
        issue(1, 3, 32'hFFFFFFFF, 0, 0, 0, 0, 0);
        watch(8, da, ra, ia, rdd, insd);
        chk("noop_complete", da >= 0, 1);
        issue(0, 0, 0, 0, 1, 3, 0, 0);
        watch(10, da, ra, ia, rdd, insd);
        chk("noop_readback", rdd, 32'h33);

        // Upper address bits alias
        issue(0, 0, 0, 0, 1, 32'h1005, 0, 0);
        watch(10, da, ra, ia, rdd, insd);
        chk("alias_read", rdd, 32'hDEADBEEF);

        // Reset one cycle into the ACCESS of a write cancels it
        issue(1, 7, 32'h55, 1, 0, 0, 0, 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        rst = 0;
        watch(8, da, ra, ia, rdd, insd);
        chk("midreset_no_complete", da, 32'hFFFFFFFF);
        issue(0, 0, 0, 0, 1, 7, 0, 0);
        watch(10, da, ra, ia, rdd, insd);
        chk("midreset_old_value", rdd, 32'h77);

        // Randomized traffic with backpressure and occasional reset
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            rst   = ($urandom_range(0, 399) == 0);
            wr_v  = ($urandom_range(0, 3) == 0);
            wr_a  = (AW-2)'($urandom_range(0, 15) | (($urandom_range(0, 1) == 1) ? ($urandom() << 12) : 0));
            wr_d  = $urandom();
            wr_c  = ($urandom_range(0, 3) != 0);
            rd_v  = ($urandom_range(0, 2) == 0);
            rd_a  = (AW-2)'($urandom_range(0, 15) | (($urandom_range(0, 1) == 1) ? ($urandom() << 12) : 0));
            ins_v = ($urandom_range(0, 2) == 0);
            ins_a = (AW-2)'($urandom_range(0, 15) | (($urandom_range(0, 1) == 1) ? ($urandom() << 12) : 0));
            rd_r  = ($urandom_range(0, 9) < 7);
            ins_r = ($urandom_range(0, 9) < 7);
        end
        @(negedge clk);
        rst = 0; wr_v = 0; rd_v = 0; ins_v = 0; rd_r = 1; ins_r = 1;
        repeat (30) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
